// File: rtl/cond_eval_pipe_pkg.sv
// cond_eval_pipe_pkg: mask/flag bit positions and the per-channel condition helper
package cond_eval_pipe_pkg;
  localparam int COND_LT = 2, COND_EQ = 1, COND_GT = 0;
  localparam int FLAG_NEG = 2, FLAG_ZERO = 1, FLAG_POS = 0;
  localparam int COND_MASK_W = 3;
  typedef logic [COND_MASK_W-1:0] cond_t;
  function automatic logic cond_hit(input cond_t f, input cond_t m);
    return (m[COND_LT] & f[FLAG_NEG]) | (m[COND_EQ] & f[FLAG_ZERO]) | (m[COND_GT] & f[FLAG_POS]);
  endfunction
endpackage

// File: rtl/cond_eval_pipe_if.sv
// cond_eval_pipe_if: valid/ready operand and result bus; COND_FLAGS_OUT_EN adds out_flags
interface cond_eval_pipe_if #(parameter int BUS_WIDTH = 8, parameter int N_CH = 4);
  logic                      in_valid, in_ready, in_signed;
  logic [N_CH*BUS_WIDTH-1:0] in_x;
  logic [N_CH*3-1:0]         in_mask;
  logic                      out_valid, out_ready, out_any, out_all;
  logic [N_CH-1:0]           out_o;
`ifdef COND_FLAGS_OUT_EN
  logic [N_CH*3-1:0]         out_flags;
`endif
  modport master (
`ifdef COND_FLAGS_OUT_EN
    input out_flags,
`endif
    output in_valid, in_x, in_mask, in_signed, out_ready,
    input in_ready, out_valid, out_o, out_any, out_all);
  modport slave (
`ifdef COND_FLAGS_OUT_EN
    output out_flags,
`endif
    input in_valid, in_x, in_mask, in_signed, out_ready,
    output in_ready, out_valid, out_o, out_any, out_all);
endinterface

// File: rtl/cond_eval_pipe_flags.sv
// cond_flags: one-hot {neg,zero,pos} classification of a single operand
module cond_flags import cond_eval_pipe_pkg::*; #(parameter int BUS_WIDTH = 8) (
  input  logic [BUS_WIDTH-1:0] i_x,
  input  logic                 i_signed,
  output cond_t                o_flags
);
  logic w_zero, w_neg;
  assign w_zero = i_x == '0;
  assign w_neg  = i_signed & i_x[BUS_WIDTH-1];
  assign o_flags[FLAG_NEG]  = w_neg;
  assign o_flags[FLAG_ZERO] = w_zero;
  assign o_flags[FLAG_POS]  = ~w_zero & ~w_neg;
endmodule

// File: rtl/cond_eval_pipe.sv
// cond_eval_pipe: 2-stage N_CH-channel zero-compare pipeline with valid/ready flow control.
// COND_FLAGS_OUT_EN carries the S1 flags into S2 and exposes them as out_flags.
module cond_eval_pipe import cond_eval_pipe_pkg::*; #(
  parameter int BUS_WIDTH = 8,
  parameter int N_CH      = 4
) (
  input logic              clk,
  input logic              rst_n,
  cond_eval_pipe_if.slave  bus
);
  logic                w_s1_adv, w_s2_adv;
  logic [N_CH*3-1:0]   w_f;
  logic [N_CH-1:0]     w_o;
  logic                r_s1_v, r_s2_v, r_any, r_all;
  logic [N_CH*3-1:0]   r_s1_f, r_s1_m;
  logic [N_CH-1:0]     r_o;
  assign w_s2_adv     = ~r_s2_v | bus.out_ready;
  assign w_s1_adv     = ~r_s1_v | w_s2_adv;
  assign bus.in_ready = w_s1_adv & rst_n;
  genvar k;
  for (k = 0; k < N_CH; k++) begin : g_ch
    cond_flags #(.BUS_WIDTH(BUS_WIDTH)) u_flags (
      .i_x      (bus.in_x[k*BUS_WIDTH +: BUS_WIDTH]),
      .i_signed (bus.in_signed),
      .o_flags  (w_f[3*k +: 3])
    );
    assign w_o[k] = cond_hit(r_s1_f[3*k +: 3], r_s1_m[3*k +: 3]);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_s1_v <= 1'b0;
      r_s1_f <= '0;
      r_s1_m <= '0;
      r_s2_v <= 1'b0;
      r_o    <= '0;
      r_any  <= 1'b0;
      r_all  <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_v <= bus.in_valid;
        r_s1_f <= w_f;
        r_s1_m <= bus.in_mask;
      end
      if (w_s2_adv) begin
        r_s2_v <= r_s1_v;
        r_o    <= w_o;
        r_any  <= |w_o;
        r_all  <= &w_o;
      end
    end
`ifdef COND_FLAGS_OUT_EN
  logic [N_CH*3-1:0] r_s2_f;
  always_ff @(posedge clk)
    if (!rst_n) r_s2_f <= '0;
    else if (w_s2_adv) r_s2_f <= r_s1_f;
  assign bus.out_flags = r_s2_f;
`endif
  assign bus.out_valid = r_s2_v;
  assign bus.out_o     = r_o;
  assign bus.out_any   = r_any;
  assign bus.out_all   = r_all;
endmodule

// File: tb/tb_cond_eval_pipe.sv
// tb_cond_eval_pipe: scoreboard bench with an arithmetic reference model of the zero compare
module tb_cond_eval_pipe;
  localparam int BW = 8, NC = 4;
  typedef struct {
    logic [NC-1:0]   o;
    logic            any;
    logic            all;
    logic [NC*3-1:0] fl;
    int              stamp;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, failures = 0, cyc = 0, rmode = 0;
  exp_t q[$];
  logic rs, ev, stall = 1'b0;
  logic [NC+1:0] held;
  exp_t e;
  cond_eval_pipe_if #(.BUS_WIDTH(BW), .N_CH(NC)) bus();
  cond_eval_pipe #(.BUS_WIDTH(BW), .N_CH(NC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [NC*BW-1:0] x, input logic [NC*3-1:0] m, input logic s);
    exp_t r;
    logic [BW-1:0] xb;
    int v;
    r.stamp = 0;
    for (int k = 0; k < NC; k++) begin
      xb = x[k*BW +: BW];
      v = s ? int'($signed(xb)) : int'(xb);
      r.o[k] = (v < 0 && m[3*k+2]) || (v == 0 && m[3*k+1]) || (v > 0 && m[3*k]);
      r.fl[3*k +: 3] = {v < 0, v == 0, v > 0};
    end
    r.any = |r.o;
    r.all = &r.o;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    rs = rst_n;
    cyc++;
    #3;
    if (!rst_n) chk("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
    if (!rs) begin
      q.delete();
      stall = 1'b0;
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_out_data", 32'({bus.out_any, bus.out_all, bus.out_o}), 32'd0);
`ifdef COND_FLAGS_OUT_EN
      chk("reset_out_flags", 32'(bus.out_flags), 32'd0);
`endif
    end else if (rst_n) begin
      ev = q.size() > 0 && cyc >= q[0].stamp + 2;
      chk("in_ready", 32'(bus.in_ready), 32'(!(q.size() == 2 && !bus.out_ready)));
      chk("out_valid", 32'(bus.out_valid), 32'(ev));
      if (stall) chk("stall_hold", 32'({bus.out_any, bus.out_all, bus.out_o}), 32'(held));
      if (ev && bus.out_ready) begin
        e = q.pop_front();
        chk("out_o", 32'(bus.out_o), 32'(e.o));
        chk("out_any_all", 32'({bus.out_any, bus.out_all}), 32'({e.any, e.all}));
`ifdef COND_FLAGS_OUT_EN
        chk("out_flags", 32'(bus.out_flags), 32'(e.fl));
`endif
      end
      stall = bus.out_valid && !bus.out_ready;
      held = {bus.out_any, bus.out_all, bus.out_o};
    end else stall = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    bus.out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'(cyc % 3 == 0) : 1'($urandom_range(0, 2) != 0);
  end

  task automatic send(input logic [NC*BW-1:0] x, input logic [NC*3-1:0] m, input logic s);
    exp_t r;
    int n = 0;
    logic acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_x = x;
    bus.in_mask = m;
    bus.in_signed = s;
    r = model(x, m, s);
    while (!acc) begin
      #3;
      if (bus.in_ready) begin
        r.stamp = cyc;
        q.push_back(r);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!acc && ++n > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=no_ready expected=ready_within_200");
        acc = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [NC*BW-1:0] rand_x();
    logic [NC*BW-1:0] x;
    logic [BW-1:0] sp[5];
    sp[0] = 8'h00; sp[1] = 8'h80; sp[2] = 8'hFF; sp[3] = 8'h7F; sp[4] = 8'h01;
    for (int k = 0; k < NC; k++)
      x[k*BW +: BW] = $urandom_range(0, 1) ? sp[$urandom_range(0, 4)] : BW'($urandom);
    return x;
  endfunction

  initial begin
    bus.in_valid = 1'b1;
    bus.in_x = '0;
    bus.in_mask = '1;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(32'h8000_05FF, {4{3'b100}}, 1'b1);
    send(32'h8000_05FF, {4{3'b001}}, 1'b0);
    send(32'h8000_05FF, {4{3'b100}}, 1'b0);
    send(32'h0000_0000, {4{3'b111}}, 1'b1);
    send(32'h8000_05FF, {4{3'b111}}, 1'b1);
    send(32'h8000_05FF, {4{3'b000}}, 1'b1);
    idle(3);
    rmode = 1;
    for (int i = 0; i < 6; i++) send(rand_x(), 12'($urandom), 1'($urandom));
    idle(10);
    rmode = 0;
    send(32'h1234_8081, {4{3'b010}}, 1'b1);
    send(32'h00FF_7F80, {4{3'b101}}, 1'b0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    send(32'h8000_05FF, {4{3'b100}}, 1'b1);
    idle(3);
    rmode = 2;
    repeat (300) begin
      send(rand_x(), 12'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    rmode = 0;
    idle(10);
    chk("drain_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
